pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It drives the stall, freeze and flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It inserts bubbles for load-use and ID-stage branch-operand hazards that the forwarding unit cannot cover, and redirects fetch on taken branches and jumps. It also freezes the whole pipeline while the data memory is not ready, and enters a sticky fault state on memory timeout.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 38 +++
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// register-index width, hazard flag bundle and the operand-match helper.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic load_use;
        logic br_ex;
        logic br_ld_mem;
    } hazard_t;

    // x0 never creates a dependency, so it is excluded from every match.
    function automatic logic reg_hit(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             reg_we,
        input logic [REG_W-1:0] rd
    );
        return use_rs && (rs != '0) && reg_we && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Purpose: flags ID-stage hazards that forwarding cannot cover (load-use, branch operands).
// Latency: purely combinational, same cycle.
// Backpressure: none; consumer decides how to stall on the flags.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_branch,
    input  logic             id_jalr,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_we,
    input  logic             mem_mem_read,
    output hazard_t          hz
);

    logic ex_hit;
    logic mem_hit;
    logic id_ctl;

    assign ex_hit  = reg_hit(id_use_rs1, id_rs1, ex_reg_we, ex_rd)
                   | reg_hit(id_use_rs2, id_rs2, ex_reg_we, ex_rd);
    assign mem_hit = reg_hit(id_use_rs1, id_rs1, mem_reg_we, mem_rd)
                   | reg_hit(id_use_rs2, id_rs2, mem_reg_we, mem_rd);
    assign id_ctl  = id_branch | id_jalr;

    // Branch compare sits in ID, so even an ALU result in EX is too late;
    // a load in MEM is too late as well, giving the two-cycle load->branch stall.
    assign hz.load_use  = ex_mem_read & ex_hit;
    assign hz.br_ex     = id_ctl & ~ex_mem_read & ex_hit;
    assign hz.br_ld_mem = id_ctl & mem_mem_read & mem_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: 5-stage pipeline stall/freeze/flush sequencing with dmem timeout fault; PIPE_CTRL_PERF_EN adds perf counters.
// Latency: all enables/flushes combinational from current inputs and registered FSM state.
// Backpressure: dmem not ready freezes PC..EX/MEM and bubbles MEM/WB; timeout locks into FAULT until reset.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_branch,
    input  logic             id_jalr,
    input  logic             id_take,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_we,
    input  logic             mem_mem_read,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_fault,
    output logic [1:0]       ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_freeze_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    hazard_t          hz;
    logic             hazard;
    logic             miss;
    logic             live;
    logic             freeze;

    hazard_detect u_hazard_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_branch    (id_branch),
        .id_jalr      (id_jalr),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_we   (mem_reg_we),
        .mem_mem_read (mem_mem_read),
        .hz           (hz)
    );

    assign hazard = |hz;
    assign miss   = dmem_req & ~dmem_ready;
    assign live   = rst_n & (state != ST_FAULT);
    assign freeze = live & miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (miss) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // Release cycle returns to RUN; it is not itself frozen.
                if (dmem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ST_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_fault    = 1'b0;
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == ST_FAULT) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
            mem_fault    = 1'b1;
        end else if (miss) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (hazard) begin
            // Branch stays in ID, so id_take is seen again once the stall clears.
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_take) begin
            if_id_flush = 1'b1;
        end
    end

    assign ctrl_state = state;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_path;
    logic redir_path;

    assign stall_path = live & ~miss & hazard;
    assign redir_path = live & ~miss & ~hazard & id_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_freeze_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (stall_path) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
            if (freeze)     perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
            if (redir_path) perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = freeze;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MEM_TIMEOUT=4: hazards, redirect, freeze, timeout and reset.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, id_branch, id_jalr, id_take;
    logic       ex_reg_we, ex_mem_read, mem_reg_we, mem_mem_read;
    logic       dmem_req, dmem_ready;
    logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_fault;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_freeze_cnt, perf_flush_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // {pc,if_id,id_ex,ex_mem we | if_id,id_ex,mem_wb flush | fault | state}
    localparam logic [9:0] V_RESET  = 10'b0000_111_0_00;
    localparam logic [9:0] V_NORM   = 10'b1111_000_0_00;
    localparam logic [9:0] V_HAZ    = 10'b0011_010_0_00;
    localparam logic [9:0] V_REDIR  = 10'b1111_100_0_00;
    localparam logic [9:0] V_FRZ_R  = 10'b0000_001_0_00;
    localparam logic [9:0] V_FRZ_W  = 10'b0000_001_0_01;
    localparam logic [9:0] V_REL    = 10'b1111_000_0_01;
    localparam logic [9:0] V_REL_HZ = 10'b0011_010_0_01;
    localparam logic [9:0] V_FAULT  = 10'b0000_001_1_10;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_branch    (id_branch),
        .id_jalr      (id_jalr),
        .id_take      (id_take),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_we   (mem_reg_we),
        .mem_mem_read (mem_mem_read),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_fault    (mem_fault),
        .ctrl_state   (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_freeze_cnt (perf_freeze_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic chk_ctl(input string tag, input logic [9:0] exp);
        #2;
        check(tag, {22'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush,
                    id_ex_flush, mem_wb_flush, mem_fault, ctrl_state}, {22'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_branch = 0; id_jalr = 0; id_take = 0;
        ex_rd = 0; ex_reg_we = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_we = 0; mem_mem_read = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic load);
        ex_rd = rd; ex_reg_we = 1; ex_mem_read = load;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        #1;
        chk_ctl("reset_hold", V_RESET);
        tick(); tick();
        rst_n = 1'b1;
        chk_ctl("idle", V_NORM);

        // load x5 in EX, add reads x5: one bubble
        tick(); set_ex(5, 1); id_rs1 = 5; id_use_rs1 = 1;
        chk_ctl("load_use", V_HAZ);
        tick(); ex_reg_we = 0; ex_mem_read = 0;
        chk_ctl("load_use_after", V_NORM);

        // load x7 then beq on rs2=x7: two stall cycles
        tick(); clr_inputs(); set_ex(7, 1); id_rs2 = 7; id_use_rs2 = 1; id_branch = 1;
        chk_ctl("ld_br_c1", V_HAZ);
        tick(); ex_reg_we = 0; ex_mem_read = 0; mem_rd = 7; mem_reg_we = 1; mem_mem_read = 1;
        chk_ctl("ld_br_c2", V_HAZ);
        tick(); mem_reg_we = 0; mem_mem_read = 0;
        chk_ctl("ld_br_c3", V_NORM);

        tick(); clr_inputs(); set_ex(0, 1); id_use_rs1 = 1;
        chk_ctl("x0_no_stall", V_NORM);

        tick(); clr_inputs(); set_ex(9, 1); id_rs2 = 9;
        chk_ctl("rs2_unused", V_NORM);

        tick(); clr_inputs(); set_ex(4, 0); id_rs1 = 4; id_use_rs1 = 1;
        chk_ctl("alu_fwd_ok", V_NORM);

        tick(); clr_inputs(); mem_rd = 6; mem_reg_we = 1; id_rs1 = 6; id_use_rs1 = 1; id_branch = 1;
        chk_ctl("br_mem_alu_ok", V_NORM);

        tick(); clr_inputs(); set_ex(12, 0); id_rs1 = 12; id_use_rs1 = 1; id_jalr = 1;
        chk_ctl("jalr_br_ex", V_HAZ);

        tick(); clr_inputs(); id_take = 1;
        chk_ctl("redirect", V_REDIR);
        tick(); id_take = 0;
        chk_ctl("redirect_after", V_NORM);

        tick(); set_ex(3, 0); id_rs1 = 3; id_use_rs1 = 1; id_branch = 1; id_take = 1;
        chk_ctl("take_with_br_ex", V_HAZ);
        tick(); ex_reg_we = 0;
        chk_ctl("take_after_stall", V_REDIR);

        tick(); clr_inputs(); dmem_req = 1; dmem_ready = 1;
        chk_ctl("ready_same_cycle", V_NORM);
        tick();
        chk_ctl("ready_same_next", V_NORM);

        // three frozen cycles then release
        dmem_ready = 0;
        chk_ctl("miss_c1", V_FRZ_R);
        tick(); chk_ctl("miss_c2", V_FRZ_W);
        tick(); chk_ctl("miss_c3", V_FRZ_W);
        tick(); dmem_ready = 1;
        chk_ctl("miss_release", V_REL);
        tick(); dmem_req = 0; dmem_ready = 0;
        chk_ctl("miss_back_run", V_NORM);

        // release cycle still honours hazards
        tick(); dmem_req = 1;
        chk_ctl("miss2_c1", V_FRZ_R);
        tick(); dmem_ready = 1; set_ex(5, 1); id_rs1 = 5; id_use_rs1 = 1;
        chk_ctl("release_hazard", V_REL_HZ);
        tick(); clr_inputs();
        chk_ctl("release_hz_after", V_NORM);

        // reset mid-WAIT
        dmem_req = 1;
        tick(); chk_ctl("wait_before_rst", V_FRZ_W);
        rst_n = 0;
        chk_ctl("rst_mid_wait", V_RESET);
        dmem_req = 0;
        tick(); rst_n = 1;
        chk_ctl("rst_mid_wait_rel", V_NORM);

        // timeout: 4 frozen cycles then sticky fault
        tick(); dmem_req = 1;
        chk_ctl("to_c1", V_FRZ_R);
        tick(); chk_ctl("to_c2", V_FRZ_W);
        tick(); chk_ctl("to_c3", V_FRZ_W);
        tick(); chk_ctl("to_c4", V_FRZ_W);
        tick(); chk_ctl("fault_enter", V_FAULT);
        dmem_ready = 1; id_take = 1;
        tick(); chk_ctl("fault_sticky1", V_FAULT);
        dmem_req = 0;
        tick(); chk_ctl("fault_sticky2", V_FAULT);
        rst_n = 0;
        chk_ctl("fault_async_rst", V_RESET);
        tick(); clr_inputs(); rst_n = 1;
        chk_ctl("post_fault_run", V_NORM);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_rst", perf_stall_cnt, 32'd0);
        check("perf_freeze_rst", perf_freeze_cnt, 32'd0);
        tick(); id_take = 1;
        tick(); id_take = 0; #2;
        check("perf_flush_one", perf_flush_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
